pkt_dispatch: RTL and testbench
===============================

PKT_DISPATCH -- requirements
Module: pkt_dispatch

Interface
REQ-001 SHALL have parameter DW, default 32, data word width (header format needs DW >= 32).
REQ-002 SHALL have parameter MAX_LEN, default 64, largest legal payload length in words.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port empty  input  1  upstream FIFO empty.
REQ-006 SHALL have port dout  input  DW  upstream FIFO head word, show-ahead (valid whenever empty=0).
REQ-007 SHALL have port pop  output  1  consume the upstream FIFO head word this cycle.
REQ-008 SHALL have port out_valid  output  4  one-hot, per-port word valid.
REQ-009 SHALL have port out_ready  input  4  per-port sink ready.
REQ-010 SHALL have port out_data  output  DW  shared output word.
REQ-011 SHALL have port out_last  output  1  out_data is the final word of its packet.
REQ-012 SHALL have port busy  output  1  high while not in IDLE or the output register is occupied.
REQ-013 SHALL have port drop_cnt  output  8  dropped-packet count (see Configuration).

Function
REQ-014 Packet SHALL be one header word plus LEN payload words; header [31:29] = dest, [7:0] = LEN, other bits ignored.
REQ-015 dest 0..3 with LEN <= MAX_LEN SHALL be valid; dest 4..7 or LEN > MAX_LEN SHALL mark the packet for drop.
REQ-016 States SHALL be IDLE, FWD, DROP.
REQ-017 IDLE: empty=0 and output register free or draining this cycle -> pop header, latch dest and LEN counter, go to FWD (valid) or DROP (invalid).
REQ-018 FWD: header, then each payload word, SHALL be loaded into one output register; out_valid[dest] SHALL assert the cycle after the word's pop.
REQ-019 A word SHALL transfer when out_valid[dest] & out_ready[dest]; out_valid and out_data SHALL hold stable until transfer.
REQ-020 pop in FWD SHALL assert only when empty=0 and (register free or transferring this cycle); sustained throughput SHALL be 1 word/cycle.
REQ-021 out_last SHALL be high with the header when LEN=0, otherwise with payload word LEN.
REQ-022 After the last word is popped, the FSM SHALL return to IDLE; the next header SHALL pop as soon as the register frees (no idle cycle required).
REQ-023 DROP: payload words SHALL be popped at 1/cycle while empty=0, nothing output; return to IDLE after LEN words (immediately when LEN=0).
REQ-024 pop SHALL never assert while empty=1; empty mid-packet SHALL stall without losing count.
REQ-025 out_ready on non-destination ports SHALL be ignored; out_valid SHALL never have more than one bit set.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, pop=0, out_valid=0, out_last=0, out_data=0, busy=0, drop_cnt=0.
REQ-027 Reset mid-packet SHALL abandon the packet; after release the next FIFO word SHALL be parsed as a header.

Configuration
REQ-028 Macro PKT_DISPATCH_DROP_CNT_EN defined: drop_cnt SHALL increment once per dropped header, saturating at 255.
REQ-029 Macro undefined: drop_cnt SHALL be constant 0 and no counter logic SHALL be built; all other behaviour identical.

Verification
REQ-030 FIFO holds header dest=2 LEN=3 + 3 words, out_ready=4'hF -> out_valid=4'b0100 for 4 consecutive cycles, out_last on 4th word only.
REQ-031 Header dest=1 LEN=0 -> single word on port 1 with out_last=1; FSM back in IDLE next cycle.
REQ-032 Header dest=5 LEN=2 + 2 words -> 3 pops, no out_valid, drop_cnt 0->1 (0 when macro undefined).
REQ-033 dest=0 LEN=4, out_ready[0] toggled 1,0,0,1,... -> out_data stable while stalled, all 5 words delivered in order, pop never with empty=1.
REQ-034 reset_n pulsed low after 2 of 6 words sent -> outputs 0 immediately; next FIFO word after release treated as header.
REQ-035 Back-to-back packets dest=3 LEN=1 then dest=0 LEN=1, ready held high -> 4 words on 4 consecutive cycles, port switch without gap.

Source files
------------

// File: rtl/pkt_dispatch.sv
// Routes packets from a show-ahead FIFO to 4 ports through one output register: 1 cycle pop->valid, 1 word/cycle,
// holds while the destination's out_ready is low; malformed packets are drained silently. Optional: PKT_DISPATCH_DROP_CNT_EN.
module pkt_dispatch #(
  parameter int DW      = 32,
  parameter int MAX_LEN = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          empty,
  input  logic [DW-1:0] dout,
  output logic          pop,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_nxt;
  logic [1:0]    r_port;
  logic [1:0]    w_port_nxt;
  logic          r_valid;
  logic          r_last;
  logic [DW-1:0] r_data;

  logic          w_pop;
  logic          w_load;
  logic          w_load_last;
  logic [2:0]    w_hdr_dest;
  logic [7:0]    w_hdr_len;
  logic          w_hdr_ok;
  logic          w_xfer;
  logic          w_free;

  assign w_hdr_dest = dout[31:29];
  assign w_hdr_len  = dout[7:0];
  assign w_hdr_ok   = ~w_hdr_dest[2] & ($unsigned(32'(w_hdr_len)) <= $unsigned(32'(MAX_LEN)));

  // The register may accept a new word in the same cycle its current word leaves.
  assign w_xfer = r_valid & out_ready[r_port];
  assign w_free = ~r_valid | w_xfer;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_port_nxt  = r_port;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!empty && w_free) begin
          w_pop     = 1'b1;
          w_cnt_nxt = w_hdr_len;
          if (w_hdr_ok) begin
            w_load      = 1'b1;
            w_load_last = (w_hdr_len == 8'd0);
            w_port_nxt  = w_hdr_dest[1:0];
            w_state_nxt = (w_hdr_len == 8'd0) ? IDLE : FWD;
          end else begin
            w_state_nxt = (w_hdr_len == 8'd0) ? IDLE : DROP;
          end
        end
      end
      FWD: begin
        if (!empty && w_free) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_load_last = (r_cnt == 8'd1);
          w_cnt_nxt   = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (!empty) begin
          w_pop     = 1'b1;
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_port  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_port  <= w_port_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_last  <= w_load_last;
      r_data  <= dout;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  // pop is combinational, so it must be gated to honour an asserted reset immediately.
  assign pop       = w_pop & reset_n;
  assign out_valid = r_valid ? (4'b0001 << r_port) : 4'b0000;
  assign out_data  = r_data;
  assign out_last  = r_last;
  assign busy      = (r_state != IDLE) | r_valid;

`ifdef PKT_DISPATCH_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop_hdr;

  assign w_drop_hdr = (r_state == IDLE) & w_pop & ~w_hdr_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop_hdr && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pkt_dispatch.sv
// Bench for pkt_dispatch: packet-level model of expected port transfers and drop count, randomized traffic.
module tb_pkt_dispatch;
  localparam int DW      = 32;
  localparam int MAX_LEN = 64;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b1;
  logic          empty     = 1'b1;
  logic [DW-1:0] dout      = '0;
  logic          pop;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = 4'h0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [7:0]    drop_cnt;

  pkt_dispatch #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
    .clock(clock), .reset_n(reset_n), .empty(empty), .dout(dout), .pop(pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } xfer_t;

  logic [DW-1:0] fifo[$];
  xfer_t         xlog[$];
  xfer_t         exp_q[$];
  int            pop_cyc[$];
  int            cyc = 0;
  bit            gap = 1'b0;
  bit            pop_pend = 1'b0;
  int            viol_pop_empty = 0;
  int            viol_onehot = 0;
  int            viol_stable = 0;
  bit            prev_hold = 1'b0;
  logic [3:0]    prev_valid = '0;
  logic [DW-1:0] prev_data = '0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_drops = 0;

  function automatic void refresh();
    empty = (fifo.size() == 0) || gap;
    dout  = empty ? DW'($urandom) : fifo[0];
  endfunction

  function automatic int exp_drop_cnt();
`ifdef PKT_DISPATCH_DROP_CNT_EN
    return (exp_drops > 255) ? 255 : exp_drops;
`else
    return 0;
`endif
  endfunction

  // Packet model: a valid packet yields its words in order on port dest, last on the final one; otherwise a drop.
  function automatic void push_pkt(input int dest, input int len);
    logic [DW-1:0] w;
    xfer_t         e;
    bit            ok;
    ok = (dest < 4) && (len <= MAX_LEN);
    w = DW'($urandom);
    w[31:29] = 3'(dest);
    w[7:0]   = 8'(len);
    for (int i = 0; i <= len; i++) begin
      if (i > 0) w = DW'($urandom);
      fifo.push_back(w);
      if (ok) begin
        e.port = dest; e.data = w; e.last = (i == len); e.cyc = 0;
        exp_q.push_back(e);
      end
    end
    if (!ok) exp_drops++;
    refresh();
  endfunction

  function automatic void begin_test();
    xlog.delete();
    exp_q.delete();
    pop_cyc.delete();
  endfunction

  always @(posedge clock) begin
    logic [DW-1:0] tmp;
    cyc++;
    #1;
    if (pop_pend && fifo.size() > 0) tmp = fifo.pop_front();
    pop_pend = 1'b0;
    refresh();
  end

  always @(negedge clock) begin
    xfer_t x;
    if (reset_n) begin
      if (pop) begin
        pop_pend = 1'b1;
        pop_cyc.push_back(cyc);
        if (empty) viol_pop_empty++;
      end
      if ($countones(out_valid) > 1) viol_onehot++;
      if (prev_hold && (out_valid !== prev_valid || out_data !== prev_data)) viol_stable++;
      prev_hold  = (out_valid != 4'h0) && ((out_valid & out_ready) == 4'h0);
      prev_valid = out_valid;
      prev_data  = out_data;
      if ((out_valid & out_ready) != 4'h0) begin
        x.port = -1;
        for (int i = 3; i >= 0; i--) if (out_valid[i]) x.port = i;
        x.data = out_data; x.last = out_last; x.cyc = cyc;
        xlog.push_back(x);
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (fifo.size() == 0 && !busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    fifo.push_back(32'h4000_0001);
    refresh();
    repeat (2) @(negedge clock);
    n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b expected 0", pop); end
    n_checks++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", out_last); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    fifo.delete();
    refresh();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit to;
    step();
    begin_test();
    out_ready = 4'hF;
    push_pkt(2, 3);
    wait_idle(50, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: got timeout expected idle"); end
    n_checks++; if (xlog.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", xlog.size()); end
    for (int i = 0; i < xlog.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (xlog[i].port !== exp_q[i].port || xlog[i].data !== exp_q[i].data || xlog[i].last !== exp_q[i].last ||
          xlog[i].cyc != xlog[0].cyc + i)
        begin n_fail++; $display("FAIL basic_word%0d: got port %0d data %h last %b cyc %0d expected port %0d data %h last %b cyc %0d",
          i, xlog[i].port, xlog[i].data, xlog[i].last, xlog[i].cyc, exp_q[i].port, exp_q[i].data, exp_q[i].last, xlog[0].cyc + i); end
    end
    if (xlog.size() > 0 && pop_cyc.size() > 0) begin
      n_checks++; if (xlog[0].cyc != pop_cyc[0] + 1) begin n_fail++; $display("FAIL basic_latency: got valid cyc %0d expected %0d", xlog[0].cyc, pop_cyc[0] + 1); end
    end
  endtask

  task automatic test_len0();
    bit to;
    step();
    begin_test();
    out_ready = 4'hF;
    push_pkt(1, 0);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (xlog.size() >= 1) begin to = 1'b0; break; end
    end
    @(negedge clock);
    n_checks++; if (to) begin n_fail++; $display("FAIL len0_timeout: got no transfer expected one"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_idle: got busy %b expected 0", busy); end
    n_checks++; if (xlog.size() != 1) begin n_fail++; $display("FAIL len0_count: got %0d expected 1", xlog.size()); end
    if (xlog.size() >= 1) begin
      n_checks++;
      if (xlog[0].port !== 1 || xlog[0].last !== 1'b1 || xlog[0].data !== exp_q[0].data)
        begin n_fail++; $display("FAIL len0_word: got port %0d last %b data %h expected port 1 last 1 data %h",
          xlog[0].port, xlog[0].last, xlog[0].data, exp_q[0].data); end
    end
  endtask

  task automatic test_drop();
    bit to;
    step();
    begin_test();
    out_ready = 4'hF;
    n_checks++; if (int'(drop_cnt) !== exp_drop_cnt()) begin n_fail++; $display("FAIL drop_pre_cnt: got %0d expected %0d", drop_cnt, exp_drop_cnt()); end
    push_pkt(5, 2);
    wait_idle(50, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL drop_timeout: got timeout expected idle"); end
    n_checks++; if (pop_cyc.size() != 3) begin n_fail++; $display("FAIL drop_pops: got %0d expected 3", pop_cyc.size()); end
    n_checks++; if (xlog.size() != 0) begin n_fail++; $display("FAIL drop_output: got %0d words expected 0", xlog.size()); end
    n_checks++; if (int'(drop_cnt) !== exp_drop_cnt()) begin n_fail++; $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, exp_drop_cnt()); end
  endtask

  task automatic test_len_limits();
    bit to;
    step();
    begin_test();
    out_ready = 4'hF;
    push_pkt(3, MAX_LEN);
    push_pkt(0, MAX_LEN + 1);
    push_pkt(2, 1);
    wait_idle(500, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL limits_timeout: got timeout expected idle"); end
    n_checks++; if (xlog.size() != exp_q.size()) begin n_fail++; $display("FAIL limits_count: got %0d expected %0d", xlog.size(), exp_q.size()); end
    for (int i = 0; i < xlog.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (xlog[i].port !== exp_q[i].port || xlog[i].data !== exp_q[i].data || xlog[i].last !== exp_q[i].last)
        begin n_fail++; $display("FAIL limits_word%0d: got port %0d data %h last %b expected port %0d data %h last %b",
          i, xlog[i].port, xlog[i].data, xlog[i].last, exp_q[i].port, exp_q[i].data, exp_q[i].last); end
    end
    n_checks++; if (int'(drop_cnt) !== exp_drop_cnt()) begin n_fail++; $display("FAIL limits_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop_cnt()); end
  endtask

  task automatic test_stall();
    bit to;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int v_stable0, v_pop0;
    step();
    begin_test();
    v_stable0 = viol_stable;
    v_pop0 = viol_pop_empty;
    push_pkt(0, 4);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      out_ready = {3'($urandom), pat[i % 4]};
      gap = ($urandom_range(0, 2) == 0);
      refresh();
      step();
      if (fifo.size() == 0 && !busy) begin to = 1'b0; break; end
    end
    gap = 1'b0;
    refresh();
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout: got timeout expected idle"); end
    n_checks++; if (xlog.size() != 5) begin n_fail++; $display("FAIL stall_count: got %0d expected 5", xlog.size()); end
    for (int i = 0; i < xlog.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (xlog[i].port !== 0 || xlog[i].data !== exp_q[i].data || xlog[i].last !== exp_q[i].last)
        begin n_fail++; $display("FAIL stall_word%0d: got port %0d data %h last %b expected port 0 data %h last %b",
          i, xlog[i].port, xlog[i].data, xlog[i].last, exp_q[i].data, exp_q[i].last); end
    end
    n_checks++; if (viol_stable != v_stable0) begin n_fail++; $display("FAIL stall_hold: got %0d changes while stalled expected 0", viol_stable - v_stable0); end
    n_checks++; if (viol_pop_empty != v_pop0) begin n_fail++; $display("FAIL stall_pop_empty: got %0d pops while empty expected 0", viol_pop_empty - v_pop0); end
  endtask

  task automatic test_back_to_back();
    bit to;
    step();
    begin_test();
    out_ready = 4'hF;
    push_pkt(3, 1);
    push_pkt(0, 1);
    wait_idle(50, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout: got timeout expected idle"); end
    n_checks++; if (xlog.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", xlog.size()); end
    for (int i = 0; i < xlog.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (xlog[i].port !== exp_q[i].port || xlog[i].data !== exp_q[i].data || xlog[i].last !== exp_q[i].last ||
          xlog[i].cyc != xlog[0].cyc + i)
        begin n_fail++; $display("FAIL b2b_word%0d: got port %0d last %b cyc %0d expected port %0d last %b cyc %0d",
          i, xlog[i].port, xlog[i].last, xlog[i].cyc, exp_q[i].port, exp_q[i].last, xlog[0].cyc + i); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    step();
    begin_test();
    out_ready = 4'hF;
    push_pkt(1, 5);
    to = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (xlog.size() >= 2) begin to = 1'b0; break; end
    end
    n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_wait: got %0d words expected 2", xlog.size()); end
    step();
    reset_n = 1'b0;
    #1;
    n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL rstmid_pop: got %b expected 0", pop); end
    n_checks++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0000", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rstmid_last: got %b expected 0", out_last); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    fifo.delete();
    begin_test();
    exp_drops = 0;
    refresh();
    step();
    step();
    reset_n = 1'b1;
    step();
    push_pkt(3, 1);
    wait_idle(50, to);
    n_checks++; if (int'(drop_cnt) !== exp_drop_cnt()) begin n_fail++; $display("FAIL rstmid_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop_cnt()); end
    n_checks++; if (xlog.size() != 2) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 2", xlog.size()); end
    for (int i = 0; i < xlog.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (xlog[i].port !== 3 || xlog[i].data !== exp_q[i].data || xlog[i].last !== exp_q[i].last)
        begin n_fail++; $display("FAIL rstmid_word%0d: got port %0d data %h last %b expected port 3 data %h last %b",
          i, xlog[i].port, xlog[i].data, xlog[i].last, exp_q[i].data, exp_q[i].last); end
    end
  endtask

  task automatic test_random();
    bit to;
    int v_stable0, v_pop0, v_hot0, len;
    step();
    begin_test();
    v_stable0 = viol_stable;
    v_pop0 = viol_pop_empty;
    v_hot0 = viol_onehot;
    for (int p = 0; p < 40; p++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MAX_LEN - 1, MAX_LEN + 2)) : int'($urandom_range(0, 6));
      push_pkt(int'($urandom_range(0, 7)), len);
    end
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      out_ready = 4'($urandom) | 4'($urandom);
      gap = ($urandom_range(0, 4) == 0);
      refresh();
      step();
      if (fifo.size() == 0 && !busy) begin to = 1'b0; break; end
    end
    gap = 1'b0;
    refresh();
    n_checks++; if (to) begin n_fail++; $display("FAIL rand_timeout: got timeout expected idle"); end
    n_checks++; if (xlog.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", xlog.size(), exp_q.size()); end
    for (int i = 0; i < xlog.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (xlog[i].port !== exp_q[i].port || xlog[i].data !== exp_q[i].data || xlog[i].last !== exp_q[i].last)
        begin n_fail++; $display("FAIL rand_word%0d: got port %0d data %h last %b expected port %0d data %h last %b",
          i, xlog[i].port, xlog[i].data, xlog[i].last, exp_q[i].port, exp_q[i].data, exp_q[i].last); end
    end
    n_checks++; if (int'(drop_cnt) !== exp_drop_cnt()) begin n_fail++; $display("FAIL rand_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop_cnt()); end
    n_checks++; if (viol_stable != v_stable0) begin n_fail++; $display("FAIL rand_hold: got %0d changes while stalled expected 0", viol_stable - v_stable0); end
    n_checks++; if (viol_pop_empty != v_pop0) begin n_fail++; $display("FAIL rand_pop_empty: got %0d pops while empty expected 0", viol_pop_empty - v_pop0); end
    n_checks++; if (viol_onehot != v_hot0) begin n_fail++; $display("FAIL rand_onehot: got %0d multi-bit cycles expected 0", viol_onehot - v_hot0); end
  endtask

  task automatic test_drop_saturate();
    bit to;
    step();
    begin_test();
    out_ready = 4'hF;
    for (int p = 0; p < 260; p++) push_pkt(int'($urandom_range(4, 7)), 0);
    wait_idle(2000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL sat_timeout: got timeout expected idle"); end
    n_checks++; if (int'(drop_cnt) !== exp_drop_cnt()) begin n_fail++; $display("FAIL sat_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop_cnt()); end
    n_checks++; if (xlog.size() != 0) begin n_fail++; $display("FAIL sat_output: got %0d words expected 0", xlog.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_drop();
    test_len_limits();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_drop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
